// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory.
// CPU MEM stage vs boot loader; fixed 3-cycle IDLE/ISSUE/RESP sequence.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_ld_rdata;
  logic [7:0]        r_wait;
  logic              w_grant;
  logic              w_gnt_ld;
  logic              w_resp;
  logic              w_rd;
  logic              w_starved;

  assign w_starved = (r_wait >= 8'(MAX_WAIT));

  always_comb begin
    w_next   = r_state;
    w_grant  = 1'b0;
    w_gnt_ld = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (cpu_req | ld_req) begin
          w_grant  = 1'b1;
          w_gnt_ld = ld_req & (~cpu_req | w_starved);
          w_next   = S_ISSUE;
        end
      end
      S_ISSUE: w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Acks and read capture are suppressed while rst is high.
  assign w_resp = (r_state == S_RESP) & ~rst;
  assign w_rd   = w_resp & ~r_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner     <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rdata <= '0;
      r_ld_rdata  <= '0;
    end else begin
      if (w_grant) begin
        r_owner <= w_gnt_ld;
        r_we    <= w_gnt_ld ? ld_we : cpu_we;
        r_addr  <= w_gnt_ld ? ld_addr : cpu_addr;
        r_wdata <= w_gnt_ld ? ld_wdata : cpu_wdata;
      end
      if (w_rd & ~r_owner) r_cpu_rdata <= mem_rdata;
      if (w_rd & r_owner)  r_ld_rdata  <= mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait <= 8'd0;
    end else if (~ld_req | w_gnt_ld) begin
      r_wait <= 8'd0;
    end else if (!w_starved) begin
      r_wait <= r_wait + 8'd1;
    end
  end

  assign mem_en    = (r_state == S_ISSUE) & ~rst;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign owner     = r_owner;

  assign cpu_ack   = w_resp & ~r_owner;
  assign ld_ack    = w_resp & r_owner;
  assign cpu_rdata = (w_rd & ~r_owner) ? mem_rdata : r_cpu_rdata;
  assign ld_rdata  = (w_rd & r_owner) ? mem_rdata : r_ld_rdata;
  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level model plus a small memory.
// Directed scenarios first, then randomized traffic with random resets.
module tb_dmem_arbiter;

  localparam int MAXW = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ack, cpu_stall;
  logic        ld_req, ld_we;
  logic [31:0] ld_addr, ld_wdata, ld_rdata;
  logic        ld_ack;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        owner;

  dmem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAXW)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .cpu_stall(cpu_stall),
    .ld_req(ld_req), .ld_we(ld_we),
    .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_rdata(ld_rdata), .ld_ack(ld_ack),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          own;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] dmem [16];
  logic [31:0] mmem [16];
  logic [31:0] m_hold [2];
  txn_t        m_cur;
  int          m_age = 0;
  int          m_starve = 0;
  bit          started = 0;
  bit          cpu_done = 0;
  bit          ld_done = 0;
  bit          s_en, s_we;
  logic [31:0] s_addr, s_wd;

  function automatic int ix(logic [31:0] a);
    return int'(a[5:2]);
  endfunction

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // m_age: 0 = no transaction, 1 = memory access, 2 = response
  task automatic check_model();
    bit          resp;
    bit          cack, lack;
    logic [31:0] rd;
    if (!started) return;
    resp = (m_age == 2) && !rst;
    cack = resp && !m_cur.own;
    lack = resp && m_cur.own;
    rd   = mmem[ix(m_cur.addr)];
    chk("m_en", mem_en, (m_age == 1) && !rst);
    chk("m_we", mem_we, m_cur.we);
    chk("m_addr", mem_addr, m_cur.addr);
    chk("m_wdata", mem_wdata, m_cur.wdata);
    chk("m_owner", owner, m_cur.own);
    chk("m_cack", cpu_ack, cack);
    chk("m_lack", ld_ack, lack);
    chk("m_crd", cpu_rdata,
        (cack && !m_cur.we) ? rd : m_hold[0]);
    chk("m_lrd", ld_rdata,
        (lack && !m_cur.we) ? rd : m_hold[1]);
    chk("m_stall", cpu_stall, cpu_req && !cack);
  endtask

  task automatic model_update();
    bit pick;
    if (rst) begin
      started  = 1;
      m_age    = 0;
      m_starve = 0;
      m_hold   = '{32'd0, 32'd0};
      m_cur    = '{0, 0, 32'd0, 32'd0};
      return;
    end
    pick = 0;
    if (m_age == 2) begin
      if (!m_cur.we)
        m_hold[m_cur.own] = mmem[ix(m_cur.addr)];
      if (m_cur.own) ld_done = 1;
      else           cpu_done = 1;
      m_age = 0;
    end else if (m_age == 1) begin
      if (m_cur.we) mmem[ix(m_cur.addr)] = m_cur.wdata;
      m_age = 2;
    end else if (cpu_req || ld_req) begin
      pick = ld_req && (!cpu_req || m_starve >= MAXW);
      if (pick) m_cur = '{1, ld_we, ld_addr, ld_wdata};
      else      m_cur = '{0, cpu_we, cpu_addr, cpu_wdata};
      m_age = 1;
    end
    if (!ld_req || pick) m_starve = 0;
    else if (m_starve < MAXW) m_starve++;
  endtask

  // Called at negedge+2 with inputs settled; returns at next negedge.
  task automatic tick();
    bit pend;
    int pidx;
    s_en   = mem_en;
    s_we   = mem_we;
    s_addr = mem_addr;
    s_wd   = mem_wdata;
    check_model();
    @(posedge clk);
    model_update();
    if (s_en && s_we) dmem[ix(s_addr)] = s_wd;
    pend = s_en && !s_we;
    pidx = ix(s_addr);
    @(negedge clk);
    mem_rdata = pend ? dmem[pidx] : $urandom;
  endtask

  function automatic logic [31:0] raddr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 15)) << 2;
    return a;
  endfunction

  initial begin
    int          ncpu;
    int          got_ld;
    int          done;
    logic [31:0] old;
    for (int i = 0; i < 16; i++) begin
      dmem[i] = 32'hC0DE_0000 | 32'(i);
      mmem[i] = 32'hC0DE_0000 | 32'(i);
    end
    dmem[4] = 32'hDEAD_BEEF; mmem[4] = 32'hDEAD_BEEF;
    dmem[8] = 32'hA5A5_0020; mmem[8] = 32'hA5A5_0020;
    rst = 1; mem_rdata = 0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0;
    @(negedge clk);
    #2; tick();
    #2; tick();
    rst = 0;
    #2;
    chk("rst_en", mem_en, 0);
    chk("rst_cack", cpu_ack, 0);
    chk("rst_lack", ld_ack, 0);
    chk("rst_own", owner, 0);
    chk("rst_crd", cpu_rdata, 0);
    tick();

    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    #2;
    chk("ld1_stall", cpu_stall, 1);
    chk("ld1_en", mem_en, 0);
    tick();
    #2;
    chk("ld2_en", mem_en, 1);
    chk("ld2_addr", mem_addr, 32'h10);
    chk("ld2_we", mem_we, 0);
    chk("ld2_stall", cpu_stall, 1);
    tick();
    #2;
    chk("ld3_ack", cpu_ack, 1);
    chk("ld3_rd", cpu_rdata, 32'hDEAD_BEEF);
    chk("ld3_stall", cpu_stall, 0);
    tick();
    cpu_req = 0;

    ld_req = 1; ld_we = 1;
    ld_addr = 32'h4; ld_wdata = 32'h1234;
    #2; tick();
    #2;
    chk("lw_en", mem_en, 1);
    chk("lw_we", mem_we, 1);
    chk("lw_addr", mem_addr, 32'h4);
    chk("lw_wd", mem_wdata, 32'h1234);
    chk("lw_cack", cpu_ack, 0);
    tick();
    #2;
    chk("lw_ack", ld_ack, 1);
    chk("lw_own", owner, 1);
    chk("lw_cack3", cpu_ack, 0);
    tick();
    ld_req = 0;
    #2; tick();

    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20;
    ld_req = 1; ld_we = 0; ld_addr = 32'h8;
    #2; tick();
    #2; chk("sim_own0", owner, 0); tick();
    #2;
    chk("sim_cack", cpu_ack, 1);
    chk("sim_lack", ld_ack, 0);
    chk("sim_crd", cpu_rdata, 32'hA5A5_0020);
    tick();
    cpu_req = 0;
    #2; tick();
    #2; chk("sim_own1", owner, 1); tick();
    #2;
    chk("sim_lack2", ld_ack, 1);
    chk("sim_lrd", ld_rdata, 32'hC0DE_0002);
    tick();
    ld_req = 0;
    #2; tick();

    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h14;
    ld_req = 1; ld_we = 0; ld_addr = 32'hC;
    ncpu = 0; got_ld = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      #2;
      if (got_ld && (cpu_ack || ld_ack)) begin
        chk("starve_regain", cpu_ack, 1);
        done = 1;
      end else if (ld_ack) begin
        got_ld = 1;
        chk("starve_ncpu", ncpu, 3);
      end else if (cpu_ack) begin
        ncpu++;
      end
      tick();
    end
    chk("starve_done", done, 1);
    cpu_req = 0; ld_req = 0;
    #2; tick();

    cpu_req = 1; cpu_we = 1;
    cpu_addr = 32'h30; cpu_wdata = 32'h5555_AAAA;
    old = dmem[12];
    #2; tick();
    rst = 1;
    #2;
    chk("ri_en", mem_en, 0);
    chk("ri_ack", cpu_ack, 0);
    tick();
    rst = 0;
    #2;
    chk("ri_own", owner, 0);
    chk("ri_addr", mem_addr, 0);
    chk("ri_we", mem_we, 0);
    chk("ri_wd", mem_wdata, 0);
    chk("ri_crd", cpu_rdata, 0);
    chk("ri_lrd", ld_rdata, 0);
    chk("ri_mem", dmem[12], old);
    tick();
    #2;
    chk("rr_en", mem_en, 1);
    chk("rr_addr", mem_addr, 32'h30);
    tick();
    #2; chk("rr_ack", cpu_ack, 1); tick();
    cpu_req = 0;

    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20;
    #2; tick();
    #2; tick();
    #2;
    chk("bb_ld_ack", cpu_ack, 1);
    chk("bb_ld_rd", cpu_rdata, 32'hA5A5_0020);
    tick();
    cpu_we = 1; cpu_addr = 32'h24; cpu_wdata = 32'h77;
    #2;
    chk("bb_hold1", cpu_rdata, 32'hA5A5_0020);
    chk("bb_noack", cpu_ack, 0);
    tick();
    #2;
    chk("bb_st_addr", mem_addr, 32'h24);
    chk("bb_st_we", mem_we, 1);
    tick();
    #2;
    chk("bb_st_ack", cpu_ack, 1);
    chk("bb_hold3", cpu_rdata, 32'hA5A5_0020);
    tick();
    cpu_req = 0;

    cpu_done = 0; ld_done = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      if (!cpu_req || cpu_done) begin
        cpu_done = 0;
        cpu_req  = ($urandom_range(0, 2) != 0);
        cpu_we   = $urandom_range(0, 1) == 1;
        cpu_addr = raddr();
        cpu_wdata = $urandom;
      end else if (m_age != 0 && !m_cur.own) begin
        cpu_we    = $urandom_range(0, 1) == 1;
        cpu_addr  = raddr();
        cpu_wdata = $urandom;
      end
      if (!ld_req || ld_done) begin
        ld_done  = 0;
        ld_req   = ($urandom_range(0, 1) != 0);
        ld_we    = $urandom_range(0, 1) == 1;
        ld_addr  = raddr();
        ld_wdata = $urandom;
      end else if (m_age != 0 && m_cur.own) begin
        ld_we    = $urandom_range(0, 1) == 1;
        ld_addr  = raddr();
        ld_wdata = $urandom;
      end
      #2; tick();
    end
    rst = 0; cpu_req = 0; ld_req = 0;
    for (int c = 0; c < 4; c++) begin
      #2; tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port data memory.
- Requester 0 is the CPU MEM stage: loads and stores by ALUResult_MEM address.
- Requester 1 is the boot/UART loader, which writes program data and reads back status.
- Grants one access at a time, drives the shared memory port, returns read data and a one-cycle ack, and raises a stall that freezes the CPU pipeline while the MEM-stage access is pending.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory.
- DATA_W, 32, data width.
- MAX_WAIT, 8, consecutive cycles of loader starvation after which the loader outranks the CPU (range 1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request, level, held until cpu_ack.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_W  CPU byte address.
- cpu_wdata  in  DATA_W  CPU store data.
- cpu_rdata  out  DATA_W  CPU load data.
- cpu_ack  out  1  one-cycle completion pulse to CPU.
- cpu_stall  out  1  pipeline freeze: cpu_req & ~cpu_ack.
- ld_req  in  1  loader request, level, held until ld_ack.
- ld_we  in  1  loader write enable.
- ld_addr  in  ADDR_W  loader address.
- ld_wdata  in  DATA_W  loader write data.
- ld_rdata  out  DATA_W  loader read data.
- ld_ack  out  1  one-cycle completion pulse to loader.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable (meaningful only with mem_en).
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en with mem_we=0.
- owner  out  1  requester of the current or last transaction (0 = CPU, 1 = loader).

Behaviour:
- FSM states are IDLE, ISSUE and RESP; every transaction takes exactly 3 cycles, IDLE -> ISSUE -> RESP -> IDLE.
- IDLE arbitration:
  - No request: stay in IDLE.
  - Only one request: grant it.
  - Both requesting: grant the loader if wait_cnt >= MAX_WAIT, else grant the CPU.
  - On a grant, register owner, we, addr and wdata from the winner, then go to ISSUE.
- ISSUE: mem_en = 1 (gated by ~rst). mem_we, mem_addr and mem_wdata come from the latched registers. Next state is RESP.
- RESP: the owner's ack = 1 for exactly this cycle.
  - Read: owner's rdata = mem_rdata this cycle, and mem_rdata is captured into that owner's rdata hold register.
  - Write: the owner's rdata register is unchanged.
  - Next state is IDLE.
- Requests are never sampled in ISSUE or RESP. A req still high in IDLE after an ack is a new transaction.
- The non-owner's rdata is held and its ack stays 0.
- Outside ISSUE: mem_en = 0; mem_we, mem_addr and mem_wdata hold their last values.
- wait_cnt (8-bit, internal):
  - Cleared when ld_req = 0 or when the loader is granted.
  - Otherwise increments each cycle ld_req = 1, saturating at MAX_WAIT.
- cpu_stall is combinational, cpu_req & ~cpu_ack. It is low in the ack cycle, so the pipeline advances on that edge.
- Request inputs changing while their own transaction is in flight have no effect on that transaction; the latched values are used.
- Reset, including mid-transaction:
  - State becomes IDLE and wait_cnt becomes 0.
  - cpu_ack, ld_ack and mem_en are 0 during and after reset; mem_en is suppressed in the rst cycle, so no partial write occurs.
  - cpu_rdata, ld_rdata, mem_addr, mem_wdata, mem_we and owner all reset to 0.
  - An aborted transaction is never acked; its requester must re-request.

Test Plan:
- CPU load only: cpu_req=1, cpu_we=0, cpu_addr=0x10, mem_rdata=0xDEADBEEF in RESP -> mem_en=1 in cycle 2 with mem_addr=0x10 and mem_we=0; cpu_ack=1 in cycle 3 with cpu_rdata=0xDEADBEEF; cpu_stall=1 in cycles 1-2 and 0 in cycle 3.
- Loader write only: ld_req=1, ld_we=1, ld_addr=0x4, ld_wdata=0x1234 -> one mem_en pulse with mem_we=1, mem_addr=0x4, mem_wdata=0x1234; ld_ack one cycle later; cpu_ack=0 throughout; owner=1.
- Simultaneous requests with wait_cnt=0: CPU granted first; loader granted in the IDLE immediately after the CPU ack, provided cpu_req is then 0. owner sequence is 0, 1.
- Starvation: cpu_req held high with back-to-back loads and ld_req held high, MAX_WAIT=8 -> CPU served until wait_cnt reaches 8; the next IDLE grants the loader; after ld_ack, wait_cnt=0 and the CPU regains priority.
- Reset in ISSUE: assert rst for 1 cycle during a CPU store -> mem_en=0 in that cycle, no ack, all outputs 0, FSM in IDLE; re-request completes normally in 3 cycles.
- Back-to-back CPU load then store (0x20 then 0x24) -> two separate 3-cycle transactions; cpu_rdata holds the load value through the store transaction.
